// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file writeback constants and helpers
package regfile_pkg;
  localparam int RF_ADDR_W  = 5;
  localparam int RF_DATA_W  = 32;
  localparam int RF_NUM_REQ = 3;
  localparam int WB_ALU     = 0;
  localparam int WB_LOAD    = 1;
  localparam int WB_MULDIV  = 2;
  function automatic int ptr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, search starts at ptr and wraps
//   req : per-requester valid
//   ptr : index searched first
//   gnt : one-hot grant, zero when no request
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter  int N  = RF_NUM_REQ,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  always_comb begin
    gnt = '0;
    for (int k = 0; k < N; k++)
      if (gnt == '0 && req[(int'(ptr) + k) % N]) gnt[(int'(ptr) + k) % N] = 1'b1;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the register-file write port with a pending-write scoreboard
//   clock/reset_n              : rising-edge clock, async active-low reset
//   req_valid/addr/data, ready : packed writeback requesters, one-hot grant
//   reserve_valid/addr, ok     : issue-stage destination reservation
//   flush                      : clears the scoreboard only
//   busy_mask, err_unreserved  : scoreboard and sticky unreserved-write flag
//   RegWrite/WriteAddr/Data    : registered register-file write port
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter  int NUM_REQ = RF_NUM_REQ,
  parameter  int ADDR_W  = RF_ADDR_W,
  parameter  int DATA_W  = RF_DATA_W,
  localparam int PW      = ptr_w(NUM_REQ),
  localparam int NREG    = 2 ** ADDR_W
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      reserve_valid,
  input  logic [ADDR_W-1:0]         reserve_addr,
  output logic                      reserve_ok,
  input  logic                      flush,
  output logic [NREG-1:0]           busy_mask,
  output logic                      err_unreserved,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         WriteAddr,
  output logic [DATA_W-1:0]         WriteData
);
  logic [PW-1:0]     ptr_q, ptr_d, gidx;
  logic [NUM_REQ-1:0] gnt;
  logic [ADDR_W-1:0] g_addr, wa_q;
  logic [DATA_W-1:0] g_data, wd_q;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              wr, rw_q, err_q, err_d;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(ptr_q),
    .gnt(gnt)
  );
  assign req_ready = gnt;
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) gidx = PW'(i);
  end
  assign g_addr     = req_addr[gidx*ADDR_W +: ADDR_W];
  assign g_data     = req_data[gidx*DATA_W +: DATA_W];
  // address 0 completes the handshake but never reaches the register file
  assign wr         = |gnt && g_addr != '0;
  assign reserve_ok = reserve_addr == '0 || !busy_q[reserve_addr];
  assign ptr_d      = |gnt ? (gidx == PW'(NUM_REQ - 1) ? '0 : gidx + 1'b1) : ptr_q;
  assign err_d      = err_q | (wr & ~busy_q[g_addr]);
  // clear is applied after set so a same-register collision ends clear; flush overrides both
  always_comb begin
    busy_d = busy_q;
    if (reserve_valid && reserve_ok) busy_d[reserve_addr] = 1'b1;
    if (wr) busy_d[g_addr] = 1'b0;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ptr_q  <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
      rw_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      rw_q   <= wr;
      if (wr) begin
        wa_q <= g_addr;
        wd_q <= g_data;
      end
    end
  assign busy_mask      = busy_q;
  assign err_unreserved = err_q;
  assign RegWrite       = rw_q;
  assign WriteAddr      = wa_q;
  assign WriteData      = wd_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vectors checked against a behavioural model and literal expectations
module tb_regfile_write_arbiter;
  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  logic              clock = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              reserve_valid;
  logic [AW-1:0]     reserve_addr;
  logic              reserve_ok;
  logic              flush;
  logic [31:0]       busy_mask;
  logic              err_unreserved;
  logic              RegWrite;
  logic [AW-1:0]     WriteAddr;
  logic [DW-1:0]     WriteData;
  int checks = 0;
  int errors = 0;

  regfile_write_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr), .reserve_ok(reserve_ok),
    .flush(flush), .busy_mask(busy_mask), .err_unreserved(err_unreserved),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: pointer as an integer, scoreboard as a bit set, write port as plain registers
  int          m_ptr;
  logic [31:0] m_busy;
  logic        m_rw, m_err;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  int          gi;
  logic [AW-1:0] ga;
  logic [DW-1:0] gd;
  logic        m_wr;
  logic [31:0] set_v, clr_v;
  logic [NR-1:0] m_ready;
  logic        m_ok;
  always @* begin
    int order[$];
    order = {};
    for (int k = 0; k < NR; k++) order.push_back((m_ptr + k) % NR);
    gi = -1;
    foreach (order[k]) if (gi < 0 && req_valid[order[k]]) gi = order[k];
    ga      = gi < 0 ? '0 : req_addr[gi*AW +: AW];
    gd      = gi < 0 ? '0 : req_data[gi*DW +: DW];
    m_wr    = gi >= 0 && ga != 0;
    m_ready = gi < 0 ? '0 : NR'(1 << gi);
    m_ok    = reserve_addr == 0 || !m_busy[reserve_addr];
    set_v   = (reserve_valid && m_ok && reserve_addr != 0) ? (32'd1 << reserve_addr) : 32'd0;
    clr_v   = m_wr ? (32'd1 << ga) : 32'd0;
  end
  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      m_ptr <= 0; m_busy <= '0; m_rw <= 0; m_wa <= '0; m_wd <= '0; m_err <= 0;
    end else begin
      m_rw <= m_wr;
      if (m_wr) begin
        m_wa <= ga;
        m_wd <= gd;
        if (!m_busy[ga]) m_err <= 1'b1;
      end
      if (gi >= 0) m_ptr <= (gi + 1) % NR;
      m_busy <= flush ? 32'd0 : ((m_busy | set_v) & ~clr_v);
    end

  always @(negedge clock) begin
    chk("cmp_ready", req_ready, m_ready);
    chk("cmp_reserve_ok", reserve_ok, m_ok);
    chk("cmp_busy", busy_mask, m_busy);
    chk("cmp_err", err_unreserved, m_err);
    chk("cmp_regwrite", RegWrite, m_rw);
    chk("cmp_waddr", WriteAddr, m_wa);
    chk("cmp_wdata", WriteData, m_wd);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    req_valid = '0; req_addr = '0; req_data = '0;
    reserve_valid = 0; reserve_addr = '0; flush = 0;
  endtask
  task automatic setreq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask
  task automatic reserve(input logic [AW-1:0] a);
    reserve_valid = 1; reserve_addr = a;
  endtask
  task automatic mid();
    @(negedge clock);
  endtask

  initial begin
    reset_n = 0;
    idle();
    tick(); tick();
    reset_n = 1;
    mid();
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_waddr", WriteAddr, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_err", err_unreserved, 0);
    // single write to r5
    tick(); reserve(5);
    mid(); chk("single_resv_ok", reserve_ok, 1);
    tick(); idle();
    chk("single_busy_set", busy_mask[5], 1);
    setreq(0, 5, 32'hDEADBEEF);
    mid(); chk("single_ready", req_ready, 3'b001);
    tick(); idle();
    chk("single_rw", RegWrite, 1);
    chk("single_wa", WriteAddr, 5);
    chk("single_wd", WriteData, 32'hDEADBEEF);
    chk("single_busy_clr", busy_mask[5], 0);
    chk("single_err", err_unreserved, 0);
    // pre-reserve r1..r3 (pointer is 1)
    reserve(1); tick(); reserve(2); tick(); reserve(3); tick(); idle();
    chk("resv_123", busy_mask, 32'h0000_000E);
    // load writes r0: handshake only
    setreq(1, 0, 32'h1234);
    mid(); chk("r0_ready", req_ready, 3'b010);
    tick(); idle();
    chk("r0_rw", RegWrite, 0);
    chk("r0_busy", busy_mask, 32'h0000_000E);
    setreq(2, 0, 32'h0);
    mid(); chk("r0b_ready", req_ready, 3'b100);
    tick(); idle();
    // fairness: pointer at 0, all three valid
    setreq(0, 1, 32'hA1); setreq(1, 2, 32'hA2); setreq(2, 3, 32'hA3);
    mid(); chk("fair_g0", req_ready, 3'b001);
    tick(); req_valid[0] = 0;
    chk("fair_rw1", RegWrite, 1); chk("fair_wa1", WriteAddr, 1);
    mid(); chk("fair_g1", req_ready, 3'b010);
    tick(); req_valid[1] = 0;
    chk("fair_rw2", RegWrite, 1); chk("fair_wa2", WriteAddr, 2);
    mid(); chk("fair_g2", req_ready, 3'b100);
    tick(); idle();
    chk("fair_rw3", RegWrite, 1); chk("fair_wa3", WriteAddr, 3); chk("fair_wd3", WriteData, 32'hA3);
    chk("fair_err", err_unreserved, 0);
    // contention: requesters 1 and 2, pointer at 0
    reserve(4); tick(); reserve(6); tick(); idle();
    setreq(1, 4, 32'hB4); setreq(2, 6, 32'hB6);
    mid(); chk("cont_g1", req_ready, 3'b010);
    tick(); req_valid[1] = 0;
    chk("cont_wa4", WriteAddr, 4);
    mid(); chk("cont_g2", req_ready, 3'b100);
    tick(); idle();
    chk("cont_rw_nobubble", RegWrite, 1); chk("cont_wa6", WriteAddr, 6);
    req_valid = 3'b111;
    mid(); chk("cont_ptr0", req_ready, 3'b001);
    tick(); idle();
    // scoreboard conflicts: pointer at 1
    reserve(7); tick();
    chk("sb_busy7", busy_mask[7], 1);
    setreq(1, 7, 32'hC7);
    mid(); chk("sb_resv7_ok", reserve_ok, 0); chk("sb_g7", req_ready, 3'b010);
    tick(); idle();
    chk("sb_clear_wins", busy_mask[7], 0); chk("sb_wa7", WriteAddr, 7);
    setreq(2, 9, 32'hC9);
    tick(); idle();
    chk("sb_err9", err_unreserved, 1); chk("sb_wa9", WriteAddr, 9);
    // different registers set and cleared together (pointer 0)
    reserve(10); tick();
    reserve(11); setreq(0, 10, 32'hCA);
    tick(); idle();
    chk("sb_set_clr", busy_mask, 32'h0000_0800);
    reserve(12); flush = 1;
    tick(); idle();
    chk("flush_busy", busy_mask, 0); chk("flush_err", err_unreserved, 1);
    // async reset between grant and edge (pointer 1)
    reserve(13); tick();
    reserve(14); setreq(1, 13, 32'hD13);
    tick(); idle();
    chk("ar_pre_rw", RegWrite, 1);
    setreq(2, 14, 32'hD14);
    #2 reset_n = 0;
    #1;
    chk("ar_rw", RegWrite, 0);
    chk("ar_busy", busy_mask, 0);
    chk("ar_err", err_unreserved, 0);
    tick(); tick();
    reset_n = 1;
    idle();
    req_valid = 3'b111;
    mid(); chk("ar_first_g0", req_ready, 3'b001);
    tick(); idle();
    chk("ar_no_write", RegWrite, 0);
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
